// File: rtl/dotseq_pkg.sv
// Shared types and constants for the dot-product sequencer.
package dotseq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    localparam int LANES         = 16;
    localparam int WORDS_PER_GRP = 4;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/dot_seq_ctrl_dot16_int8.sv
// dot16_int8: combinational 16-lane int8 dot product with a signed input offset.
// Each lane computes (sext(x)+offset) * sext(w) (10b x 8b -> 18b), then all
// lanes are summed to 22 bits and sign-extended to 32.
module dot16_int8
    import dotseq_pkg::*;
(
    input  logic [LANES*8-1:0] lanes,
    input  logic [LANES*8-1:0] weights,
    input  logic [8:0]         offset,
    output logic [31:0]        sum
);

    logic [LANES-1:0][17:0] prod;
    logic signed [21:0]     total;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [9:0] x_off;
        logic signed [7:0] wt;
        assign x_off   = $signed({{2{lanes[8*i+7]}}, lanes[8*i +: 8]}) + $signed({offset[8], offset});
        assign wt      = $signed(weights[8*i +: 8]);
        assign prod[i] = 18'(x_off * wt);
    end

    // Sum all lane products with sign extension to the 22-bit accumulator width.
    always_comb begin
        total = '0;
        for (int i = 0; i < LANES; i++) begin
            total = total + $signed({{4{prod[i][17]}}, prod[i]});
        end
    end

    assign sum = {{10{total[21]}}, total};

endmodule

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: command-driven sequencer for a 16-lane int8 dot product over
// N groups of 4 words from two scratchpads, returning one 32-bit result.
// Build option: define DOTSEQ_SAT_EN to saturate the accumulator on signed
// overflow instead of wrapping.
module dot_seq_ctrl
    import dotseq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_in_base,
    input  logic [ADDR_W-1:0] cmd_flt_base,
    input  logic [8:0]        cmd_offset,
    input  logic [31:0]       cmd_bias,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] flt_addr,
    input  logic [31:0]       in_rdata,
    input  logic [31:0]       flt_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              busy
);

    state_t state, state_nxt;

    logic [LEN_W-1:0]  len_q, g;
    logic [1:0]        w;
    logic [ADDR_W-1:0] in_base, flt_base;
    logic [8:0]        off_q;
    logic [31:0]       acc, acc_nxt, rsp_q, dot;
    logic [WORDS_PER_GRP-1:0][31:0] in_lanes, flt_lanes;
    logic              last_grp;

    assign last_grp  = (g == len_q - LEN_W'(1));
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign mem_rd_en = (state == S_FETCH);
    assign rsp_valid = (state == S_DONE);
    assign rsp_data  = rsp_q;

    // Word address within the buffer is 4g+w; truncation gives the modulo wrap.
    assign in_addr  = in_base  + ADDR_W'({g, w});
    assign flt_addr = flt_base + ADDR_W'({g, w});

    dot16_int8 u_dot (
        .lanes   (in_lanes),
        .weights (flt_lanes),
        .offset  (off_q),
        .sum     (dot)
    );

    // Accumulator update: wrapping add, or clamp on signed overflow when enabled.
    always_comb begin
        logic [31:0] raw;
        raw     = acc + dot;
        acc_nxt = raw;
`ifdef DOTSEQ_SAT_EN
        if (acc[31] == dot[31] && raw[31] != acc[31]) begin
            acc_nxt = acc[31] ? SAT_MIN : SAT_MAX;
        end
`else
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) state_nxt = (cmd_len == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (w == 2'd3) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ACC;
            S_ACC:   state_nxt = last_grp ? S_DONE : S_FETCH;
            S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, counters, lane capture, accumulator and response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            g         <= '0;
            w         <= '0;
            in_base   <= '0;
            flt_base  <= '0;
            off_q     <= '0;
            acc       <= '0;
            rsp_q     <= '0;
            in_lanes  <= '0;
            flt_lanes <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    len_q    <= cmd_len;
                    in_base  <= cmd_in_base;
                    flt_base <= cmd_flt_base;
                    off_q    <= cmd_offset;
                    acc      <= cmd_bias;
                    g        <= '0;
                    w        <= '0;
                    if (cmd_len == '0) rsp_q <= cmd_bias;
                end
                S_FETCH: begin
                    // w wraps 3->0, leaving it ready for the next group.
                    w <= w + 2'd1;
                    if (w != 2'd0) begin
                        in_lanes[w - 2'd1]  <= in_rdata;
                        flt_lanes[w - 2'd1] <= flt_rdata;
                    end
                end
                S_WAIT: begin
                    in_lanes[3]  <= in_rdata;
                    flt_lanes[3] <= flt_rdata;
                end
                S_ACC: begin
                    acc <= acc_nxt;
                    if (last_grp) rsp_q <= acc_nxt;
                    else          g     <= g + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl with a registered-read scratchpad model.
module tb_dot_seq_ctrl;

    localparam int AW = 12;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] cmd_in_base, cmd_flt_base;
    logic [8:0]    cmd_offset;
    logic [31:0]   cmd_bias;
    logic          mem_rd_en;
    logic [AW-1:0] in_addr, flt_addr;
    logic [31:0]   in_rdata, flt_rdata;
    logic          rsp_valid, rsp_ready, busy;
    logic [31:0]   rsp_data;

    dot_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_in_base  (cmd_in_base),
        .cmd_flt_base (cmd_flt_base),
        .cmd_offset   (cmd_offset),
        .cmd_bias     (cmd_bias),
        .mem_rd_en    (mem_rd_en),
        .in_addr      (in_addr),
        .flt_addr     (flt_addr),
        .in_rdata     (in_rdata),
        .flt_rdata    (flt_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] in_mem  [4096];
    logic [31:0] flt_mem [4096];

    // Scratchpads: data is valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            in_rdata  <= in_mem[in_addr];
            flt_rdata <= flt_mem[flt_addr];
        end
    end

    logic [AW-1:0] in_log[$];
    logic [AW-1:0] flt_log[$];

    // Record every read address pair.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            in_log.push_back(in_addr);
            flt_log.push_back(flt_addr);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [AW-1:0] ib, input logic [AW-1:0] fb, input int n,
                        input logic [31:0] iv, input logic [31:0] fv);
        for (int i = 0; i < n; i++) begin
            in_mem[AW'(ib + AW'(i))]  = iv;
            flt_mem[AW'(fb + AW'(i))] = fv;
        end
    endtask

    task automatic issue(input logic [LW-1:0] len, input logic [AW-1:0] ib, input logic [AW-1:0] fb,
                         input logic [8:0] off, input logic [31:0] bias);
        @(negedge clk);
        cmd_len      = len;
        cmd_in_base  = ib;
        cmd_flt_base = fb;
        cmd_offset   = off;
        cmd_bias     = bias;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Issue a command and wait (bounded) for rsp_valid; latency counts the
    // acceptance cycle as 1.
    task automatic run_cmd(input logic [LW-1:0] len, input logic [AW-1:0] ib, input logic [AW-1:0] fb,
                           input logic [8:0] off, input logic [31:0] bias,
                           output int lat, output logic [31:0] data);
        issue(len, ib, fb, off, bias);
        lat = 1;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk);
            #1 lat++;
        end
        data = rsp_data;
    endtask

    task automatic chk_released(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
        chk({tag, "_in_addr"},   32'(in_addr),   32'd0);
        chk({tag, "_flt_addr"},  32'(flt_addr),  32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    int          lat;
    logic [31:0] data, held;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_in_base = '0;
        cmd_flt_base = '0;
        cmd_offset = '0;
        cmd_bias  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            in_mem[i]  = '0;
            flt_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk) reset = 1'b0;

        // 0 inputs, +128 offset, weight 1: 16 lanes * 128 = 2048, latency 7.
        fill(12'h010, 12'h020, 4, 32'h0000_0000, 32'h0101_0101);
        run_cmd(16'd1, 12'h010, 12'h020, 9'd128, 32'd0, lat, data);
        chk("t1_lat", 32'(lat), 32'd7);
        chk("t1_data", data, 32'd2048);
        chk_released("t1");

        // -128 + 128 = 0 on every lane.
        fill(12'h010, 12'h020, 4, 32'h8080_8080, 32'h7F7F_7F7F);
        run_cmd(16'd1, 12'h010, 12'h020, 9'd128, 32'd0, lat, data);
        chk("t2_lat", 32'(lat), 32'd7);
        chk("t2_data", data, 32'd0);
        chk_released("t2");

        // Two groups: 2 * 16 * 255 * 127 - 5; filter base wraps past 0xFFF.
        in_log.delete();
        flt_log.delete();
        fill(12'h100, 12'hFFC, 8, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
        run_cmd(16'd2, 12'h100, 12'hFFC, 9'd128, -32'sd5, lat, data);
        chk("t3_lat", 32'(lat), 32'd13);
        chk("t3_data", data, 32'd1036315);
        chk("t3_nrd", 32'(in_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < in_log.size(); i++) begin
            chk($sformatf("t3_in_addr%0d", i),  32'(in_log[i]),  32'(AW'(12'h100 + AW'(i))));
            chk($sformatf("t3_flt_addr%0d", i), 32'(flt_log[i]), 32'(AW'(12'hFFC + AW'(i))));
        end
        chk_released("t3");

        // Zero-length command returns the bias next cycle without reading.
        in_log.delete();
        run_cmd(16'd0, 12'h000, 12'h000, 9'd128, 32'h1234_5678, lat, data);
        chk("t4_lat", 32'(lat), 32'd1);
        chk("t4_data", data, 32'h1234_5678);
        chk("t4_nrd", 32'(in_log.size()), 32'd0);
        chk_released("t4");

        // Negative offset and weights: (5-1)*(-2)*16 = -128, +100 -> -28.
        fill(12'h040, 12'h050, 4, 32'h0505_0505, 32'hFEFE_FEFE);
        run_cmd(16'd1, 12'h040, 12'h050, 9'h1FF, 32'd100, lat, data);
        chk("t5_data", data, 32'hFFFF_FFE4);
        chk_released("t5");

        // Distinct words per slot: sum_k 4*(k+1)^2 = 120; catches slot mix-ups.
        for (int k = 0; k < 4; k++) begin
            in_mem[12'h060 + k]  = {4{8'(k + 1)}};
            flt_mem[12'h070 + k] = {4{8'(k + 1)}};
        end
        run_cmd(16'd1, 12'h060, 12'h070, 9'd0, 32'd0, lat, data);
        chk("t6_data", data, 32'd120);
        chk_released("t6");

        // Overflow past 0x7FFFFFFF: clamp or wrap depending on the build.
        fill(12'h010, 12'h020, 4, 32'h0000_0000, 32'h0101_0101);
        run_cmd(16'd1, 12'h010, 12'h020, 9'd128, 32'h7FFF_FFF0, lat, data);
`ifdef DOTSEQ_SAT_EN
        chk("t7_sat", data, 32'h7FFF_FFFF);
`else
        chk("t7_wrap", data, 32'h8000_07F0);
`endif
        chk_released("t7");

        // Reset in the FETCH of the third group of a 5-group command.
        fill(12'h200, 12'h300, 20, 32'h0101_0101, 32'h0101_0101);
        issue(16'd5, 12'h200, 12'h300, 9'd0, 32'd7);
        repeat (13) @(posedge clk);
        #1;
        chk("t8_rd_en", 32'(mem_rd_en), 32'd1);
        chk("t8_in_addr", 32'(in_addr), 32'h209);
        chk("t8_flt_addr", 32'(flt_addr), 32'h309);
        reset = 1'b1;
        #1 chk_reset_outputs("t8");
        @(negedge clk) reset = 1'b0;

        // Stalled response: outputs hold while rsp_ready stays low.
        rsp_ready = 1'b0;
        fill(12'h010, 12'h020, 4, 32'h0000_0000, 32'h0101_0101);
        run_cmd(16'd1, 12'h010, 12'h020, 9'd128, 32'd1, lat, data);
        chk("t9_data", data, 32'd2049);
        held = rsp_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t9_vld%0d", i),  32'(rsp_valid), 32'd1);
            chk($sformatf("t9_data%0d", i), rsp_data,        32'd2049);
            chk($sformatf("t9_rdy%0d", i),  32'(cmd_ready), 32'd0);
        end
        @(negedge clk) rsp_ready = 1'b1;
        chk_released("t9");
        chk("t9_data_kept", rsp_data, held);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
